// File: rtl/cbd_poly_writer_if.sv
// Handshake and RAM write-port bundle for cbd_poly_writer.
// The environment drives the master side; the writer block takes the slave side.
interface cbd_poly_writer_if #(
    parameter int N  = 256,
    parameter int CW = 3,
    parameter int DW = 12
);
    logic            in_valid;
    logic            in_ready;
    logic [N*CW-1:0] coeff_in;
    logic            mem_we;
    logic            mem_ready;
    logic [7:0]      mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            done;
    logic            err_range;
    logic            busy;

    modport master (
        output in_valid, coeff_in, mem_ready,
        input  in_ready, mem_we, mem_addr, mem_wdata, done, err_range, busy
    );

    modport slave (
        input  in_valid, coeff_in, mem_ready,
        output in_ready, mem_we, mem_addr, mem_wdata, done, err_range, busy
    );
endinterface

// File: rtl/cbd_poly_writer.sv
// Captures one CBD-sampled polynomial, reduces each coefficient into 0..Q-1 and streams it to RAM.
// Optional macro CBD_PAIR_WRITE_EN: two reduced coefficients per write beat (24-bit data, 128 beats).
module cbd_poly_writer #(
    parameter int ETA = 2,
    parameter int Q   = 3329,
    parameter int CW  = 3,
    parameter int N   = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    cbd_poly_writer_if.slave   bus
);
`ifdef CBD_PAIR_WRITE_EN
    localparam int PER_BEAT = 2;
`else
    localparam int PER_BEAT = 1;
`endif
    localparam int BEATS = N / PER_BEAT;
    localparam int DW    = 12 * PER_BEAT;
    localparam logic [7:0] LAST_IDX = 8'(BEATS - 1);
    localparam logic signed [12:0] ETA_S = 13'(ETA);
    localparam logic signed [12:0] Q_S   = 13'(Q);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      idx_q, idx_d;
    logic [N*CW-1:0] cap_q, cap_d;
    logic            in_ready_q, in_ready_d;
    logic            mem_we_q, mem_we_d;
    logic [7:0]      mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            done_q, done_d;
    logic            err_range_q, err_range_d;
    logic            busy_q, busy_d;
    logic            capture_s;
    logic            accept_s;

    function automatic logic signed [12:0] sext(input logic [CW-1:0] c);
        return {{(13-CW){c[CW-1]}}, c};
    endfunction

    function automatic logic [11:0] red(input logic [CW-1:0] c);
        logic signed [12:0] t;
        t = sext(c);
        if (t < 13'sd0) begin
            t = t + Q_S;
        end else begin
            t = t;
        end
        return t[11:0];
    endfunction

    function automatic logic any_out_of_range(input logic [N*CW-1:0] v);
        logic bad;
        logic signed [12:0] t;
        bad = 1'b0;
        for (int i = 0; i < N; i++) begin
            t = sext(v[i*CW +: CW]);
            bad = bad | (t > ETA_S) | (t < -ETA_S);
        end
        return bad;
    endfunction

    function automatic logic [DW-1:0] beat_word(input logic [N*CW-1:0] v, input logic [7:0] k);
`ifdef CBD_PAIR_WRITE_EN
        return {red(v[(2*int'(k)+1)*CW +: CW]), red(v[(2*int'(k))*CW +: CW])};
`else
        return red(v[int'(k)*CW +: CW]);
`endif
    endfunction

    // Next-state and next-output computation; outputs are loaded one cycle ahead so they come straight from flops.
    always_comb begin
        capture_s   = (state_q == ST_IDLE) && bus.in_valid && in_ready_q;
        accept_s    = (state_q == ST_WRITE) && mem_we_q && bus.mem_ready;
        state_d     = state_q;
        idx_d       = idx_q;
        cap_d       = cap_q;
        in_ready_d  = in_ready_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_range_d = err_range_q;
        busy_d      = busy_q;
        case (state_q)
            ST_IDLE: begin
                in_ready_d = 1'b1;
                mem_we_d   = 1'b0;
                busy_d     = 1'b0;
                if (capture_s) begin
                    state_d     = ST_WRITE;
                    cap_d       = bus.coeff_in;
                    idx_d       = 8'd0;
                    in_ready_d  = 1'b0;
                    mem_we_d    = 1'b1;
                    busy_d      = 1'b1;
                    mem_addr_d  = 8'd0;
                    mem_wdata_d = beat_word(bus.coeff_in, 8'd0);
                    err_range_d = any_out_of_range(bus.coeff_in);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (accept_s && (idx_q == LAST_IDX)) begin
                    state_d  = ST_DONE;
                    mem_we_d = 1'b0;
                    done_d   = 1'b1;
                end else if (accept_s) begin
                    idx_d       = idx_q + 8'd1;
                    mem_addr_d  = idx_q + 8'd1;
                    mem_wdata_d = beat_word(cap_q, idx_q + 8'd1);
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b0;
                mem_we_d   = 1'b0;
                busy_d     = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any polynomial in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= 8'd0;
            cap_q       <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 8'd0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_range_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cap_q       <= cap_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_range_q <= err_range_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.done      = done_q;
    assign bus.err_range = err_range_q;
    assign bus.busy      = busy_q;
endmodule
